// File: rtl/min_arb_pkg.sv
// Shared types and constants for the minimum-cost round-robin arbiter.
// Lane i owns cost bits [CW*i +: CW] of the packed cost bus.
package min_arb_pkg;

   localparam int NREQ = 4;
   localparam int CW   = 3;
   localparam int IDW  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_GRANT = 2'd2
   } state_t;

   function automatic logic [CW-1:0] cost_of(input logic [NREQ*CW-1:0] costs,
                                             input logic [IDW-1:0]     lane);
      return costs[lane*CW +: CW];
   endfunction

endpackage

// File: rtl/min_select_rr.sv
// Combinational winner search: lowest cost among masked lanes, ties going
// to the first lane at or after 'start' in circular order.
module min_select_rr
   import min_arb_pkg::*;
(
   input  logic [NREQ*CW-1:0] cost_snap,
   input  logic [NREQ-1:0]    mask,
   input  logic [IDW-1:0]     start,
   output logic [IDW-1:0]     win_id,
   output logic               found
);

   logic [IDW-1:0] w_lane     [NREQ];
   logic [CW-1:0]  w_rot_cost [NREQ];
   logic           w_rot_mask [NREQ];
   logic [CW-1:0]  w_best_cost;
   logic [IDW-1:0] w_best_k;

   // Position gi of the rotated view holds lane (start + gi) mod NREQ.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      assign w_lane[gi]     = start + IDW'(gi);
      assign w_rot_cost[gi] = cost_of(cost_snap, w_lane[gi]);
      assign w_rot_mask[gi] = mask[w_lane[gi]];
   end

   // Strict less-than keeps the earliest rotated position on a tie.
   always_comb begin
      found       = 1'b0;
      w_best_cost = '0;
      w_best_k    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_rot_mask[k] && (!found || (w_rot_cost[k] < w_best_cost))) begin
            found       = 1'b1;
            w_best_cost = w_rot_cost[k];
            w_best_k    = IDW'(k);
         end
      end
   end

   assign win_id = start + w_best_k;

endmodule

// File: rtl/min_cost_arbiter.sv
// Four-lane arbiter for the display write path: snapshot requests, pick the
// cheapest lane, then hold the grant until release, requester drop or timeout.
module min_cost_arbiter
   import min_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] cost,
   input  logic               i_release,
   output logic [NREQ-1:0]    grant,
   output logic [IDW-1:0]     grant_id,
   output logic               grant_valid,
   output logic               timeout,
   output logic               busy
);

   state_t              r_state;
   state_t              w_state_next;
   logic [NREQ-1:0]     r_req_snap;
   logic [NREQ*CW-1:0]  r_cost_snap;
   logic [IDW-1:0]      r_rr_ptr;
   logic [15:0]         r_hold_cnt;
   logic [NREQ-1:0]     r_grant;
   logic [IDW-1:0]      r_grant_id;
   logic                r_grant_valid;
   logic                r_timeout;

   logic [IDW-1:0]      w_win_id;
   logic                w_found;
   logic [NREQ-1:0]     w_win_onehot;
   logic                w_req_gid;
   logic                w_hold_limit;
   logic                w_drop;

   min_select_rr u_select (
      .cost_snap (r_cost_snap),
      .mask      (r_req_snap),
      .start     (r_rr_ptr),
      .win_id    (w_win_id),
      .found     (w_found)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign w_win_onehot[gi] = (w_win_id == IDW'(gi));
   end

   // Only the live request of the granted lane is watched while holding.
   assign w_req_gid    = req[r_grant_id];
   assign w_hold_limit = (MAX_HOLD != 0) && (r_hold_cnt == 16'(MAX_HOLD - 1));
   assign w_drop       = i_release || !w_req_gid || w_hold_limit;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (|req) w_state_next = ST_EVAL;
         ST_EVAL:  w_state_next = w_found ? ST_GRANT : ST_IDLE;
         ST_GRANT: if (w_drop) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_req_snap    <= '0;
         r_cost_snap   <= '0;
         r_rr_ptr      <= '0;
         r_hold_cnt    <= '0;
         r_grant       <= '0;
         r_grant_id    <= '0;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_req_snap  <= req;
                  r_cost_snap <= cost;
               end
            end
            ST_EVAL: begin
               r_grant       <= w_found ? w_win_onehot : '0;
               r_grant_id    <= w_win_id;
               r_grant_valid <= w_found;
               r_hold_cnt    <= '0;
            end
            ST_GRANT: begin
               if (w_drop) begin
                  r_grant       <= '0;
                  r_grant_valid <= 1'b0;
                  r_rr_ptr      <= r_grant_id + IDW'(1);
                  // A release on the limit cycle wins over the timeout.
                  r_timeout     <= !i_release && w_req_gid;
               end else if (r_hold_cnt != 16'hFFFF) begin
                  r_hold_cnt <= r_hold_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_id    = r_grant_id;
   assign grant_valid = r_grant_valid;
   assign timeout     = r_timeout;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_min_cost_arbiter.sv
// Directed scenarios plus random traffic, every cycle compared against a
// transaction-level reference of the arbitration rules.
module tb_min_cost_arbiter;

   localparam int MH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] cost;
   logic        rel;
   logic [3:0]  grant;
   logic [1:0]  grant_id;
   logic        grant_valid;
   logic        timeout;
   logic        busy;

   always #5 clk = ~clk;

   min_cost_arbiter #(.MAX_HOLD(MH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .cost        (cost),
      .i_release   (rel),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout),
      .busy        (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;

   // Reference: 0 = waiting, 1 = deciding, 2 = holding.
   int        m_phase = 0;
   bit [3:0]  m_sreq  = 0;
   bit [11:0] m_scost = 0;
   int        m_ptr   = 0;
   int        m_cnt   = 0;
   bit [3:0]  m_grant = 0;
   int        m_gid   = 0;
   bit        m_valid = 0;
   bit        m_tout  = 0;

   function automatic int pick(bit [3:0] r, bit [11:0] c, int ptr);
      int best  = -1;
      int bestc = 99;
      for (int k = 0; k < 4; k++) begin
         int ln = (ptr + k) % 4;
         int cv = int'((c >> (3 * ln)) & 12'h7);
         if (r[ln] && cv < bestc) begin
            best  = ln;
            bestc = cv;
         end
      end
      return best;
   endfunction

   function automatic bit [11:0] pack(int a, int b, int c, int d);
      bit [2:0] a3 = 3'(a);
      bit [2:0] b3 = 3'(b);
      bit [2:0] c3 = 3'(c);
      bit [2:0] d3 = 3'(d);
      return {d3, c3, b3, a3};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_phase = 0; m_sreq = 0; m_scost = 0; m_ptr = 0; m_cnt = 0;
         m_grant = 0; m_gid = 0; m_valid = 0; m_tout = 0;
         return;
      end
      m_tout = 0;
      case (m_phase)
         0: if (req != 0) begin
               m_sreq  = req;
               m_scost = cost;
               m_phase = 1;
            end
         1: begin
               m_gid   = pick(m_sreq, m_scost, m_ptr);
               m_grant = 4'(1 << m_gid);
               m_valid = 1;
               m_cnt   = 0;
               m_phase = 2;
               $display("txn: cycle %0d grant lane %0d", cycle, m_gid);
            end
         default: begin
               if (rel || !req[m_gid] || (MH != 0 && m_cnt == MH - 1)) begin
                  m_tout  = !rel && req[m_gid];
                  m_grant = 0;
                  m_valid = 0;
                  m_ptr   = (m_gid + 1) % 4;
                  m_phase = 0;
               end else if (m_cnt < 65535) begin
                  m_cnt++;
               end
            end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      cycle++;
      #1;
      check("m_grant", grant, m_grant);
      check("m_valid", grant_valid, m_valid);
      check("m_timeout", timeout, m_tout);
      check("m_busy", busy, m_phase != 0);
      if (m_valid) check("m_gid", grant_id, m_gid);
   endtask

   task automatic do_reset();
      rst = 1; tick(); rst = 0;
   endtask

   initial begin
      rst = 1; req = 0; cost = 0; rel = 0;
      tick();
      check("rst_grant", grant, 0);
      check("rst_valid", grant_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      rst = 0;

      // Single request, then release; tie afterwards exposes rr_ptr=3.
      req = 4'b0100; cost = pack(0, 0, 5, 0);
      tick();
      check("t1_eval_nogrant", grant_valid, 0);
      tick();
      check("t1_grant", grant, 4'b0100);
      check("t1_gid", grant_id, 2);
      rel = 1; tick(); rel = 0; req = 0;
      check("t1_release", grant, 0);
      req = 4'hF; cost = pack(4, 4, 4, 4);
      tick(); tick();
      check("t1_ptr3", grant_id, 3);
      req = 0; tick();
      check("t1_drop", grant_valid, 0);

      // Distinct costs; cost change while holding is ignored.
      req = 4'hF; cost = pack(6, 3, 1, 7);
      tick(); tick();
      check("t2_gid", grant_id, 2);
      cost = pack(6, 3, 7, 7);
      tick();
      check("t2_hold_gid", grant_id, 2);
      check("t2_hold_valid", grant_valid, 1);
      rel = 1; tick(); rel = 0; req = 0;

      // Masked cheaper lane, then pointer moves past winner.
      do_reset();
      req = 4'b1011; cost = pack(5, 2, 0, 2);
      tick(); tick();
      check("t3_gid", grant_id, 1);
      rel = 1; tick(); rel = 0;
      check("t3_released", grant_valid, 0);
      tick(); tick();
      check("t3_gid_next", grant_id, 3);
      rel = 1; tick(); rel = 0; req = 0;

      // Round-robin on equal costs with one idle cycle between grants.
      do_reset();
      req = 4'hF; cost = pack(4, 4, 4, 4);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         check("t4_gid", grant_id, i % 4);
         rel = 1; tick(); rel = 0;
         check("t4_idle_busy", busy, 0);
         check("t4_idle_valid", grant_valid, 0);
         tick();
         check("t4_eval_busy", busy, 1);
         check("t4_eval_valid", grant_valid, 0);
         tick();
      end
      req = 0; tick();

      // Hold timeout after MH cycles.
      do_reset();
      req = 4'b0001; cost = 0;
      tick(); tick();
      check("t5_hold", grant_valid, 1);
      for (int i = 0; i < MH - 1; i++) begin
         tick();
         check("t5_hold", grant_valid, 1);
      end
      tick();
      check("t5_timeout", timeout, 1);
      check("t5_grant_off", grant, 0);
      req = 0; tick();
      check("t5_pulse_end", timeout, 0);
      req = 4'hF; cost = pack(4, 4, 4, 4);
      tick(); tick();
      check("t5_ptr1", grant_id, 1);
      req = 0; tick();

      // Release on the last allowed cycle is a normal release.
      do_reset();
      req = 4'b0001; cost = 0;
      tick(); tick();
      for (int i = 0; i < MH - 1; i++) tick();
      rel = 1; tick(); rel = 0;
      check("t5b_no_timeout", timeout, 0);
      check("t5b_valid", grant_valid, 0);
      req = 0; tick();

      // Requester drop, then reset while holding.
      do_reset();
      req = 4'b0010; cost = pack(1, 6, 2, 3);
      tick(); tick();
      check("t6_gid", grant_id, 1);
      req = 0; tick();
      check("t6_drop_valid", grant_valid, 0);
      check("t6_drop_timeout", timeout, 0);
      req = 4'hF; cost = pack(4, 4, 4, 4);
      tick(); tick();
      check("t6_gid2", grant_id, 2);
      rst = 1; tick(); rst = 0;
      check("t6_rst_grant", grant, 0);
      check("t6_rst_valid", grant_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_timeout", timeout, 0);
      tick(); tick();
      check("t6_ptr0", grant_id, 0);

      // Random traffic against the reference.
      req = 0; rel = 0;
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rst  = ($urandom_range(0, 299) == 0);
         req  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         if ($urandom_range(0, 1) == 1) req = req | 4'($urandom);
         cost = 12'($urandom);
         rel  = ($urandom_range(0, 5) == 0);
         tick();
      end
      rst = 0; req = 0; rel = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/min_cost_arbiter.md
Name: min_cost_arbiter

Overview:
- Shares one downstream resource (e.g. the LCD write path) among 4 requesters.
- Each requester presents a 3-bit cost; the lowest-cost active requester wins.
- Ties are broken round-robin.
- The grant is held until release, requester drop, or hold timeout. It sits in front of the LCD/display datapath and sequences which lane's data is serviced.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 for this revision.
- CW, 3, cost width per requester.
- MAX_HOLD, 16, max GRANT cycles before forced release; 0 disables timeout; range 0..65535.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- req  input  4  request per lane, level-sensitive
- cost  input  12  packed costs, lane i = cost[3i+2:3i]
- release  input  1  single-cycle pulse from granted lane: done with resource
- grant  output  4  one-hot grant, registered
- grant_id  output  2  index of granted lane, valid when grant_valid=1
- grant_valid  output  1  high while any grant is held
- timeout  output  1  one-cycle pulse on forced release
- busy  output  1  high in EVAL or GRANT

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, rr_ptr=0, hold_cnt=0, snapshot regs=0. Reset overrides everything, including mid-GRANT (grant drops the next cycle, no timeout pulse).
- States: IDLE, EVAL, GRANT.
- IDLE, req!=0: capture req_snap<=req and cost_snap<=cost, go EVAL. If req==0, stay in IDLE.
- EVAL (1 cycle):
  - Candidates are lanes with req_snap=1. Non-requesting lanes are excluded regardless of cost.
  - Winner is the minimum unsigned cost among candidates.
  - Ties: the first minimum-cost lane scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Register grant/grant_id, grant_valid<=1, hold_cnt<=0, go GRANT.
- Latency: req sampled in IDLE at edge t gives grant visible after edge t+2.
- GRANT:
  - hold_cnt increments each cycle.
  - Release condition: release=1, OR req[grant_id]=0, OR (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - On release: grant/grant_valid<=0 next edge, rr_ptr<=(grant_id+1) mod 4, go IDLE.
- Timeout: pulses timeout=1 for the cycle grant drops, only if no release and req[grant_id] still high.
  - Simultaneous release + timeout counts as a normal release: no timeout pulse.
- release outside GRANT is ignored.
- Changes to cost/req during EVAL or GRANT do not affect the current arbitration; only req[grant_id] drop is observed in GRANT.
- Back-to-back: release at edge t gives grant low after t+1 (IDLE), new grant after t+3. This guarantees at least 1 idle cycle between grants.
- hold_cnt is 16 bits and saturates at 65535 when MAX_HOLD=0.
- busy = (state!=IDLE). grant_id holds its last value when grant_valid=0 (don't-care).

Decomposition:
- Package min_arb_pkg:
  - state encoding (IDLE=2'd0, EVAL=2'd1, GRANT=2'd2)
  - NREQ and CW localparams
  - cost-slice helper constant/function
- Sub-module min_select_rr (combinational):
  - inputs: cost_snap[11:0], mask[3:0], start[1:0]
  - outputs: win_id[1:0], found
  - implemented as rotate-by-start, priority-min over 4, un-rotate.
- The top holds the FSM, snapshot regs, rr_ptr, hold_cnt and timeout.

Test Plan:
1. Single request: req=4'b0100, lane2 cost=5 → grant=4'b0100, grant_id=2 two cycles after req sampled. release pulse → grant=0 next cycle, rr_ptr=3.
2. Distinct costs, all req=4'b1111, costs A=6,B=3,C=1,D=7 → grant_id=2. Changing cost C to 7 during GRANT leaves the grant unchanged.
3. Masked lower cost: req=4'b1011, costs A=5,B=2,C=0,D=2, rr_ptr=0 → grant_id=1 (lane2 ignored). After release, rr_ptr=2; same stimulus → grant_id=3.
4. Round-robin ties: req=4'b1111, all costs=4, release each grant immediately → grant_id sequence 0,1,2,3,0, with exactly 1 idle cycle between grants.
5. Timeout: MAX_HOLD=8, single req lane0, no release → grant_valid high exactly 8 cycles, then timeout=1 for 1 cycle with grant=0, rr_ptr=1. A variant with release on the 8th cycle gives timeout=0.
6. Requester drop / reset: lane1 granted, req[1]→0 → grant drops next cycle with no timeout. Separately, rst=1 mid-GRANT → next cycle grant=0, grant_valid=0, busy=0, and rr_ptr=0 (checked by subsequent tie resolving to lane0).
